op_encoder: RTL and testbench

Instruction encoder and program writer: the inverse of the instruction decoder. Accepts field-level instruction descriptions (opcode, register indices, immediate) over a valid/ready stream, packs each into the 16-bit op word the decoder expects, buffers the words in a small FIFO and writes them to consecutive instruction-memory addresses over a req/ack port. Sits between the host/loader logic and the instruction memory write port.

---
 rtl/op_encoder_pkg.sv | 97 +++++++++
 rtl/op_encoder_fifo.sv | 69 ++++++
 rtl/op_encoder.sv | 148 ++++++++++++++
 tb/tb_op_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/op_encoder_pkg.sv
// Shared definitions for the instruction encoder.
//   - FSM state encoding for the session controller.
//   - Field slice positions of the 16-bit op word.
//   - Opcode constants (mirror of def.h used by the decoder).
//   - Helpers: opcode legality check and field packing.
package op_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Field slices of the op word: {OPC, F2, F1, F0}.
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int F2_HI  = 11;
    localparam int F2_LO  = 8;
    localparam int F1_HI  = 7;
    localparam int F1_LO  = 4;
    localparam int F0_HI  = 3;
    localparam int F0_LO  = 0;

    // Opcode values shared with the decoder; 4'hE and 4'hF are undefined.
    localparam logic [3:0] OPC_AND   = 4'h0;
    localparam logic [3:0] OPC_OR    = 4'h1;
    localparam logic [3:0] OPC_ADD   = 4'h2;
    localparam logic [3:0] OPC_SUB   = 4'h3;
    localparam logic [3:0] OPC_CMP   = 4'h4;
    localparam logic [3:0] OPC_JMPR  = 4'h5;
    localparam logic [3:0] OPC_ADDI  = 4'h6;
    localparam logic [3:0] OPC_SUBI  = 4'h7;
    localparam logic [3:0] OPC_CMPI  = 4'h8;
    localparam logic [3:0] OPC_LOAD  = 4'h9;
    localparam logic [3:0] OPC_STORE = 4'hA;
    localparam logic [3:0] OPC_JMP   = 4'hB;
    localparam logic [3:0] OPC_JNZ   = 4'hC;
    localparam logic [3:0] OPC_LI    = 4'hD;

    // LOAD/STORE carry only a 4-bit offset, so a wider immediate is illegal.
    function automatic logic opc_legal(input logic [3:0] opc, input logic [7:0] imm);
        case (opc)
            OPC_LOAD, OPC_STORE:                 return (imm[7:4] == 4'h0);
            OPC_AND, OPC_OR, OPC_ADD, OPC_SUB,
            OPC_CMP, OPC_JMPR, OPC_ADDI, OPC_SUBI,
            OPC_CMPI, OPC_JMP, OPC_JNZ, OPC_LI:  return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] pack_op(input logic [3:0] opc,
                                            input logic [3:0] dst,
                                            input logic [3:0] src0,
                                            input logic [3:0] src1,
                                            input logic [7:0] imm);
        logic [15:0] w;
        w = '0;
        w[OPC_HI:OPC_LO] = opc;
        case (opc)
            OPC_AND, OPC_OR, OPC_ADD, OPC_SUB: begin
                w[F2_HI:F2_LO] = src1;
                w[F1_HI:F1_LO] = src0;
                w[F0_HI:F0_LO] = dst;
            end
            OPC_CMP, OPC_JMPR: begin
                w[F2_HI:F2_LO] = src1;
                w[F1_HI:F1_LO] = src0;
            end
            OPC_ADDI, OPC_SUBI: begin
                w[F2_HI:F2_LO] = dst;
                w[F1_HI:F0_LO] = imm;
            end
            OPC_CMPI: begin
                w[F2_HI:F2_LO] = src1;
                w[F1_HI:F0_LO] = imm;
            end
            OPC_LOAD: begin
                w[F2_HI:F2_LO] = src1;
                w[F1_HI:F1_LO] = imm[3:0];
                w[F0_HI:F0_LO] = dst;
            end
            OPC_STORE: begin
                w[F2_HI:F2_LO] = src1;
                w[F1_HI:F1_LO] = src0;
                w[F0_HI:F0_LO] = imm[3:0];
            end
            OPC_JMP, OPC_JNZ, OPC_LI: begin
                w[F2_HI:F1_LO] = imm;
                w[F0_HI:F0_LO] = dst;
            end
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/op_encoder_fifo.sv
// op_fifo: synchronous DEPTH x WIDTH FIFO with full/empty flags and level.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata : write a word (ignored when full)
//   pop        : drop the head word (ignored when empty)
//   rdata      : head word (undefined contents when empty)
//   full/empty : occupancy flags; level: current number of entries
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; the level counter alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/op_encoder.sv
// op_encoder: packs field-level instruction bundles into 16-bit op words,
// buffers them and writes them to consecutive instruction-memory addresses.
//   clk, rst            : clock, asynchronous active-high reset
//   start, base_addr    : begin a session (only in IDLE) at base_addr
//   in_*                : valid/ready bundle stream (opcode, regs, imm, last)
//   imem_req/ack/addr/wdata : memory write port, one word per ack
//   busy, done          : session active / one-cycle end-of-session pulse
//   err, err_idx        : sticky illegal-bundle flag and first illegal index
//   count               : words written this session
module op_encoder
    import op_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opc,
    input  logic [3:0]  in_dst,
    input  logic [3:0]  in_src0,
    input  logic [3:0]  in_src1,
    input  logic [7:0]  in_imm,
    input  logic        in_last,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic [7:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  err_idx,
    output logic [8:0]  count
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  count_q, count_d;
    logic [8:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic [8:0]  err_idx_q, err_idx_d;

    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [15:0]   fifo_head;
    logic          accept, legal, push, pop, start_ok, drained;

    assign legal    = opc_legal(in_opc, in_imm);
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign pop      = !fifo_empty && imem_ack;
    assign start_ok = (state_q == ST_IDLE) && start;
    // FIFO will be empty after this edge; lets done follow the last ack directly.
    assign drained  = fifo_empty || ((fifo_level == LW'(1)) && pop);

    op_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (pack_op(in_opc, in_dst, in_src0, in_src1, in_imm)),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (drained) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == ST_RUN) && !fifo_full;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
    end

    // Session datapath: write address, word count, bundle index, error capture.
    always_comb begin
        addr_d    = addr_q;
        count_d   = count_q;
        idx_d     = idx_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        if (start_ok) begin
            addr_d    = base_addr;
            count_d   = '0;
            idx_d     = '0;
            err_d     = 1'b0;
            err_idx_d = '0;
        end else begin
            if (pop) begin
                addr_d  = addr_q + 8'd1;
                count_d = count_q + 9'd1;
            end
            if (accept) begin
                idx_d = idx_q + 9'd1;
                if (!legal && !err_q) begin
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            addr_q    <= addr_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign imem_req   = !fifo_empty;
    // Head storage is unreset, so present zero while nothing is queued.
    assign imem_wdata = fifo_empty ? 16'h0000 : fifo_head;
    assign imem_addr  = addr_q;
    assign err        = err_q;
    assign err_idx    = err_idx_q;
    assign count      = count_q;

endmodule

// File: tb/tb_op_encoder.sv
// Directed testbench for op_encoder (DEPTH = 4).
module tb_op_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opc = '0, in_dst = '0, in_src0 = '0, in_src1 = '0;
    logic [7:0]  in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        busy, done, err;
    logic [8:0]  err_idx, count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    int done_cyc = 0;
    logic [7:0]  cap_addr[$];
    logic [15:0] cap_data[$];

    logic [3:0]  opc_tab[14];
    logic [15:0] exp_tab[14];

    op_encoder #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
        .in_dst(in_dst), .in_src0(in_src0), .in_src1(in_src1),
        .in_imm(in_imm), .in_last(in_last), .imem_req(imem_req),
        .imem_ack(imem_ack), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: a handshake seen mid-cycle completes on the next edge.
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ack) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
            last_ack_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_session(input logic [7:0] base);
        @(posedge clk); #1;
        cap_addr.delete();
        cap_data.delete();
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] opc, input logic [3:0] dst, input logic [3:0] s0,
                        input logic [3:0] s1, input logic [7:0] imm, input logic last);
        bit ok;
        ok = 1'b0;
        in_opc = opc; in_dst = dst; in_src0 = s0; in_src1 = s1; in_imm = imm;
        in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            check("send_timeout", 32'(ok), 32'd1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        check({tag, "_done"}, 32'(got), 32'd1);
    endtask

    initial begin
        opc_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                    4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
        exp_tab = '{16'h0321, 16'h1321, 16'h2321, 16'h3321, 16'h4320, 16'h5320, 16'h61A5,
                    16'h71A5, 16'h83A5, 16'h9351, 16'hA325, 16'hBA51, 16'hCA51, 16'hDA51};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", 32'(imem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(count), 0);
        rst = 1'b0;

        // Single ADD bundle
        imem_ack = 1'b1;
        start_session(8'h10);
        check("single_busy", 32'(busy), 1);
        send(4'h2, 4'h1, 4'h2, 4'h3, 8'h00, 1'b1);
        check("single_req_lat", 32'(imem_req), 1);
        check("single_wdata_lat", 32'(imem_wdata), 32'h2321);
        wait_done("single");
        check("single_nwr", 32'(cap_addr.size()), 1);
        if (cap_addr.size() == 1) begin
            check("single_addr", 32'(cap_addr[0]), 32'h10);
            check("single_data", 32'(cap_data[0]), 32'h2321);
        end
        check("single_done_lat", 32'(done_cyc - last_ack_cyc), 1);
        check("single_count", 32'(count), 1);

        // Every opcode, dst=1 src0=2 src1=3, imm A5 (05 for LOAD/STORE)
        start_session(8'h20);
        for (int i = 0; i < 14; i++)
            send(opc_tab[i], 4'h1, 4'h2, 4'h3,
                 (opc_tab[i] == 4'h9 || opc_tab[i] == 4'hA) ? 8'h05 : 8'hA5, i == 13);
        wait_done("allops");
        check("allops_nwr", 32'(cap_addr.size()), 14);
        for (int i = 0; i < 14 && i < cap_addr.size(); i++) begin
            check($sformatf("allops_data_%0d", i), 32'(cap_data[i]), 32'(exp_tab[i]));
            check($sformatf("allops_addr_%0d", i), 32'(cap_addr[i]), 32'h20 + 32'(i));
        end
        check("allops_count", 32'(count), 14);
        check("allops_err", 32'(err), 0);

        // Backpressure: ack low while bundles are offered
        imem_ack = 1'b0;
        start_session(8'h40);
        for (int i = 1; i <= 4; i++) send(4'h2, 4'(i), 4'h0, 4'h0, 8'h00, 1'b0);
        @(negedge clk);
        check("bp_ready_full", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_addr_stable", 32'(imem_addr), 32'h40);
            check("bp_data_stable", 32'(imem_wdata), 32'h2001);
        end
        fork
            begin
                send(4'h2, 4'h5, 4'h0, 4'h0, 8'h00, 1'b0);
                send(4'h2, 4'h6, 4'h0, 4'h0, 8'h00, 1'b1);
            end
            begin
                @(posedge clk); #1;
                imem_ack = 1'b1;
            end
        join
        wait_done("bp");
        check("bp_nwr", 32'(cap_addr.size()), 6);
        for (int i = 0; i < 6 && i < cap_addr.size(); i++) begin
            check($sformatf("bp_data_%0d", i), 32'(cap_data[i]), 32'h2001 + 32'(i));
            check($sformatf("bp_addr_%0d", i), 32'(cap_addr[i]), 32'h40 + 32'(i));
        end
        check("bp_count", 32'(count), 6);

        // Illegal STORE as third bundle
        start_session(8'h60);
        send(4'h2, 4'h1, 4'h0, 4'h0, 8'h00, 1'b0);
        send(4'h2, 4'h2, 4'h0, 4'h0, 8'h00, 1'b0);
        send(4'hA, 4'h1, 4'h2, 4'h3, 8'h15, 1'b0);
        send(4'h2, 4'h3, 4'h0, 4'h0, 8'h00, 1'b0);
        send(4'h2, 4'h4, 4'h0, 4'h0, 8'h00, 1'b1);
        wait_done("ill");
        check("ill_err", 32'(err), 1);
        check("ill_err_idx", 32'(err_idx), 2);
        check("ill_count", 32'(count), 4);
        check("ill_nwr", 32'(cap_addr.size()), 4);
        if (cap_addr.size() >= 3) begin
            check("ill_addr_after", 32'(cap_addr[2]), 32'h62);
            check("ill_data_after", 32'(cap_data[2]), 32'h2003);
        end

        // Session holding only an illegal (undefined opcode) last bundle
        start_session(8'h70);
        check("zero_err_cleared", 32'(err), 0);
        send(4'hF, 4'h1, 4'h2, 4'h3, 8'h00, 1'b1);
        wait_done("zero");
        check("zero_nwr", 32'(cap_addr.size()), 0);
        check("zero_count", 32'(count), 0);
        check("zero_err", 32'(err), 1);
        check("zero_err_idx", 32'(err_idx), 0);

        // Address wrap
        start_session(8'hFE);
        for (int i = 1; i <= 4; i++) send(4'h2, 4'(i), 4'h0, 4'h0, 8'h00, i == 4);
        wait_done("wrap");
        check("wrap_nwr", 32'(cap_addr.size()), 4);
        for (int i = 0; i < 4 && i < cap_addr.size(); i++)
            check($sformatf("wrap_addr_%0d", i), 32'(cap_addr[i]), 32'((8'hFE + i) & 8'hFF));
        check("wrap_final_addr", 32'(imem_addr), 32'h02);

        // Reset mid-session with two words pending and err set
        imem_ack = 1'b0;
        start_session(8'h80);
        send(4'h2, 4'h1, 4'h0, 4'h0, 8'h00, 1'b0);
        send(4'h2, 4'h2, 4'h0, 4'h0, 8'h00, 1'b0);
        send(4'hE, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
        check("mid_req", 32'(imem_req), 1);
        check("mid_err", 32'(err), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(imem_req), 0);
        check("mid_rst_addr", 32'(imem_addr), 0);
        check("mid_rst_wdata", 32'(imem_wdata), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_err_idx", 32'(err_idx), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_req", 32'(imem_req), 0);
        end
        check("post_rst_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
